// File: rtl/nes_button_events_if.sv
// Event stream handshake between nes_button_events (master) and its consumer (slave).
interface nes_button_events_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_btn;
  logic       evt_press;
  logic       evt_repeat;

  modport master (output evt_valid, evt_btn, evt_press, evt_repeat, input evt_ready);
  modport slave  (input evt_valid, evt_btn, evt_press, evt_repeat, output evt_ready);
endinterface

// File: rtl/nes_button_events.sv
// NES button levels -> debounced press/release event queue with per-button pending slots.
// Optional auto-repeat is built only when NES_AUTOREPEAT_EN is defined.
module nes_btn_lane #(
  parameter int DEB        = 16,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit RPT        = 1'b0,
  parameter int DELAY      = 1000,
  parameter int PERIOD     = 250
) (
  input  logic CLK,
  input  logic reset_n,
  input  logic en,
  input  logic raw,
  output logic held,
  output logic tog,
  output logic rpt
);
  localparam int CW = $clog2(DEB + 1);

  logic          s1, s2, lvl, hit;
  logic [CW-1:0] cnt;

  assign lvl = ACTIVE_LOW ? ~s2 : s2;
  assign hit = (lvl != held) && (cnt == CW'(DEB - 1));

  // tog pulses in the same cycle held flips, so the slot stage sees the new level
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= ACTIVE_LOW;
      s2   <= ACTIVE_LOW;
      cnt  <= '0;
      held <= 1'b0;
      tog  <= 1'b0;
    end else begin
      tog <= en & hit;
      if (en) begin
        s1 <= raw;
        s2 <= s1;
        if (lvl == held || hit) cnt <= '0;
        else                    cnt <= cnt + 1'b1;
        if (hit) held <= ~held;
      end
    end
  end

  if (RPT) begin : g_rpt
    localparam int RW = $clog2((DELAY > PERIOD ? DELAY : PERIOD) + 1);
    logic [RW-1:0] rc;
    logic          ph, fire;

    // ph=0 waits out the initial delay, ph=1 paces subsequent repeats
    assign fire = held && !hit && (rc == (ph ? RW'(PERIOD - 1) : RW'(DELAY - 1)));

    always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
        rc  <= '0;
        ph  <= 1'b0;
        rpt <= 1'b0;
      end else begin
        rpt <= en & fire;
        if (en) begin
          if (!held || hit) begin
            rc <= '0;
            ph <= 1'b0;
          end else if (fire) begin
            rc <= '0;
            ph <= 1'b1;
          end else begin
            rc <= rc + 1'b1;
          end
        end
      end
    end
  end else begin : g_norpt
    assign rpt = 1'b0;
  end
endmodule

module nes_button_events #(
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter int         FIFO_DEPTH      = 4,
  parameter bit         BTN_ACTIVE_LOW  = 1'b1,
  parameter logic [7:0] REPEAT_MASK     = 8'hF0,
  parameter int         REPEAT_DELAY    = 1000,
  parameter int         REPEAT_PERIOD   = 250
) (
  input  logic                 CLK,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [7:0]           btn,
  output logic [7:0]           held,
  output logic                 overflow,
  input  logic                 clr_overflow,
  nes_button_events_if.master  evt
);
`ifdef NES_AUTOREPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [2:0] idx;
    logic       press;
    logic       rep;
  } evt_t;

  logic [7:0] tog, rpt, occ, dir, rep, occ_n, dir_n, rep_n, deq;
  logic [2:0] sel;
  logic       any, lost, push, pop, full, empty;
  logic [AW:0] wp, rp;
  evt_t       mem [FIFO_DEPTH];
  evt_t       head;

  for (genvar i = 0; i < 8; i++) begin : g_lane
    nes_btn_lane #(
      .DEB(DEBOUNCE_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW), .RPT(RPT_ON && REPEAT_MASK[i]),
      .DELAY(REPEAT_DELAY), .PERIOD(REPEAT_PERIOD)
    ) u_lane (
      .CLK(CLK), .reset_n(reset_n), .en(en), .raw(btn[i]),
      .held(held[i]), .tog(tog[i]), .rpt(rpt[i])
    );
  end

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop   = evt.evt_valid && evt.evt_ready;
  assign push  = any && (!full || pop);
  assign head  = mem[rp[AW-1:0]];

  assign evt.evt_valid  = !empty;
  assign evt.evt_btn    = head.idx;
  assign evt.evt_press  = head.press;
  assign evt.evt_repeat = RPT_ON & head.rep;

  always_comb begin
    sel = 3'd0;
    any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (occ[i]) begin
        sel = 3'(i);
        any = 1'b1;
      end
    end
  end

  // A slot leaving for the FIFO this cycle counts as empty for an arriving edge
  always_comb begin
    deq   = 8'd0;
    occ_n = occ;
    dir_n = dir;
    rep_n = rep;
    lost  = 1'b0;
    if (push) deq[sel] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (deq[i]) occ_n[i] = 1'b0;
      if (tog[i]) begin
        if (occ_n[i] && dir_n[i] != held[i]) begin
          occ_n[i] = 1'b0;
          lost     = 1'b1;
        end else begin
          occ_n[i] = 1'b1;
          dir_n[i] = held[i];
          rep_n[i] = 1'b0;
        end
      end else if (rpt[i] && !occ_n[i]) begin
        occ_n[i] = 1'b1;
        dir_n[i] = 1'b1;
        rep_n[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      occ      <= '0;
      dir      <= '0;
      rep      <= '0;
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      occ <= occ_n;
      dir <= dir_n;
      rep <= rep_n;
      if (push) begin
        mem[wp[AW-1:0]] <= '{idx: sel, press: dir[sel], rep: rep[sel]};
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      if (lost)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_nes_button_events.sv
// Self-checking bench for nes_button_events: directed vector table, corner sequences,
// and randomized button traffic against a window-based reference model.
module tb_nes_button_events;
  localparam int         DEB   = 16;
  localparam int         RD    = 1000;
  localparam int         RP    = 250;
  localparam logic [7:0] RMASK = 8'hF0;

  logic       CLK = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b1;
  logic       clr_overflow = 1'b0;
  logic [7:0] btn = 8'hFF;
  logic [7:0] held;
  logic       overflow;

  nes_button_events_if bus ();

  nes_button_events #(
    .DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(4), .BTN_ACTIVE_LOW(1'b1),
    .REPEAT_MASK(RMASK), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLK(CLK), .reset_n(reset_n), .en(en), .btn(btn), .held(held),
    .overflow(overflow), .clr_overflow(clr_overflow), .evt(bus)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic int code(input int i, input logic p, input logic r);
    return i * 4 + (p ? 2 : 0) + (r ? 1 : 0);
  endfunction

  typedef struct {
    logic [7:0] b;
    logic       rdy;
    int         n;
    logic       v;
    logic [2:0] idx;
    logic       pr;
    logic [7:0] h;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  // reference model state
  logic [7:0] hist [$];
  logic [7:0] mheld;
  int         rise_t [8];
  int         kcyc;
  int         expq [$];

  task automatic model_reset();
    hist.delete();
    for (int j = 0; j < DEB + 2; j++) hist.push_back(8'h00);
    mheld = 8'h00;
    kcyc  = 0;
    expq.delete();
    for (int i = 0; i < 8; i++) rise_t[i] = 0;
  endtask

  // A level flips once the last DEB synchronized samples (2-cycle lag) all disagree with it
  task automatic model_step(input logic [7:0] b);
    logic all_diff;
    int   d;
    hist.push_back(~b);
    kcyc++;
    for (int i = 0; i < 8; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++)
        if (hist[hist.size() - 3 - j][i] == mheld[i]) all_diff = 1'b0;
      if (all_diff) begin
        mheld[i] = ~mheld[i];
        expq.push_back(code(i, mheld[i], 1'b0));
        if (mheld[i]) rise_t[i] = kcyc;
      end else if (mheld[i] && RMASK[i]) begin
`ifdef NES_AUTOREPEAT_EN
        d = kcyc - rise_t[i];
        if (d == RD || (d > RD && (d - RD) % RP == 0)) expq.push_back(code(i, 1'b1, 1'b1));
`else
        d = 0;
`endif
      end
    end
    if (hist.size() > DEB + 4) void'(hist.pop_front());
  endtask

  task automatic pop_check();
    int c, f;
    c = code(int'(bus.evt_btn), bus.evt_press, bus.evt_repeat);
    f = -1;
    for (int q = 0; q < expq.size(); q++)
      if ((expq[q] >> 2) == int'(bus.evt_btn)) begin
        f = q;
        break;
      end
    if (f < 0) begin
      check("rnd_unexpected_evt", c, 32'hFFFF);
    end else begin
      check("rnd_evt", c, expq[f]);
      expq.delete(f);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ev_t [$];
    int ev_c [$];
    int nseen;
    int seg, glen;
    logic [7:0] base, gmask, b;

    vt[0]  = '{8'hFF, 1'b1,  2, 1'b0, 3'd0, 1'b0, 8'h00};
    vt[1]  = '{8'hFE, 1'b0, 19, 1'b0, 3'd0, 1'b0, 8'h01};
    vt[2]  = '{8'hFE, 1'b0,  1, 1'b1, 3'd0, 1'b1, 8'h01};
    vt[3]  = '{8'hFE, 1'b1,  1, 1'b0, 3'd0, 1'b0, 8'h01};
    vt[4]  = '{8'hF6, 1'b1, 10, 1'b0, 3'd0, 1'b0, 8'h01};
    vt[5]  = '{8'hFE, 1'b1, 20, 1'b0, 3'd0, 1'b0, 8'h01};
    vt[6]  = '{8'hFF, 1'b1, 20, 1'b1, 3'd0, 1'b0, 8'h00};
    vt[7]  = '{8'hFF, 1'b1,  1, 1'b0, 3'd0, 1'b0, 8'h00};
    vt[8]  = '{8'h76, 1'b0, 20, 1'b1, 3'd0, 1'b1, 8'h89};
    vt[9]  = '{8'h76, 1'b1,  1, 1'b1, 3'd3, 1'b1, 8'h89};
    vt[10] = '{8'h76, 1'b1,  1, 1'b1, 3'd7, 1'b1, 8'h89};
    vt[11] = '{8'h76, 1'b1,  1, 1'b0, 3'd0, 1'b0, 8'h89};
    vt[12] = '{8'hFF, 1'b1, 25, 1'b0, 3'd0, 1'b0, 8'h00};

    // reset state
    bus.evt_ready = 1'b0;
    cyc(2);
    check("rst_valid", bus.evt_valid, 0);
    check("rst_btn", bus.evt_btn, 0);
    check("rst_press", bus.evt_press, 0);
    check("rst_repeat", bus.evt_repeat, 0);
    check("rst_held", held, 0);
    check("rst_overflow", overflow, 0);
    reset_n = 1'b1;

    for (int r = 0; r < NV; r++) begin
      btn = vt[r].b;
      bus.evt_ready = vt[r].rdy;
      cyc(vt[r].n);
      check($sformatf("vec%0d_valid", r), bus.evt_valid, vt[r].v);
      check($sformatf("vec%0d_held", r), held, vt[r].h);
      if (vt[r].v) begin
        check($sformatf("vec%0d_btn", r), bus.evt_btn, vt[r].idx);
        check($sformatf("vec%0d_press", r), bus.evt_press, vt[r].pr);
        check($sformatf("vec%0d_repeat", r), bus.evt_repeat, 0);
      end
    end

    // en low freezes the debounce count mid-way
    bus.evt_ready = 1'b0;
    btn = 8'hFE;
    cyc(10);
    en = 1'b0;
    cyc(30);
    check("en_frz_valid", bus.evt_valid, 0);
    check("en_frz_held", held, 0);
    en = 1'b1;
    cyc(9);
    check("en_resume_early", bus.evt_valid, 0);
    cyc(1);
    check("en_resume_valid", bus.evt_valid, 1);
    check("en_resume_btn", bus.evt_btn, 0);
    bus.evt_ready = 1'b1;
    btn = 8'hFF;
    cyc(25);
    check("en_clean_valid", bus.evt_valid, 0);
    check("en_clean_held", held, 0);

    // six presses with the consumer stalled, then cancel a pending one
    bus.evt_ready = 1'b0;
    btn = 8'hC0;
    cyc(30);
    check("ovf_held6", held, 8'h3F);
    check("ovf_pre", overflow, 0);
    btn = 8'hE0;
    cyc(20);
    check("ovf_set", overflow, 1);
    check("ovf_held5", held, 8'h1F);
    bus.evt_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("ovf_drain%0d_valid", k), bus.evt_valid, 1);
      check($sformatf("ovf_drain%0d_btn", k), bus.evt_btn, k);
      check($sformatf("ovf_drain%0d_press", k), bus.evt_press, 1);
      cyc(1);
    end
    check("ovf_drain_empty", bus.evt_valid, 0);
    check("ovf_sticky", overflow, 1);
    clr_overflow = 1'b1;
    cyc(1);
    clr_overflow = 1'b0;
    check("ovf_clr", overflow, 0);
    btn = 8'hFF;
    cyc(30);
    check("ovf_clean_valid", bus.evt_valid, 0);
    check("ovf_clean_held", held, 0);

`ifdef NES_AUTOREPEAT_EN
    // hold Up: press then repeats at +1000, +1250, +1500
    bus.evt_ready = 1'b1;
    btn = 8'hEF;
    for (int c = 1; c <= 1600; c++) begin
      cyc(1);
      if (bus.evt_valid) begin
        ev_t.push_back(c);
        ev_c.push_back(code(int'(bus.evt_btn), bus.evt_press, bus.evt_repeat));
      end
    end
    check("rpt_up_count", ev_t.size(), 4);
    for (int k = 0; k < 4 && k < ev_t.size(); k++) begin
      check($sformatf("rpt_up_time%0d", k), ev_t[k], (k == 0) ? 20 : 20 + RD + (k - 1) * RP);
      check($sformatf("rpt_up_code%0d", k), ev_c[k], code(4, 1'b1, k != 0));
    end
    btn = 8'hFF;
    cyc(40);
    btn = 8'hFE;
    nseen = 0;
    for (int c = 1; c <= 1300; c++) begin
      cyc(1);
      if (bus.evt_valid) begin
        nseen++;
        check("rpt_a_norepeat", bus.evt_repeat, 0);
      end
    end
    check("rpt_a_count", nseen, 1);
    btn = 8'hFF;
    cyc(40);
`endif

    // async reset with three events queued
    bus.evt_ready = 1'b0;
    btn = 8'h76;
    cyc(22);
    check("arst_pre_valid", bus.evt_valid, 1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_valid", bus.evt_valid, 0);
    check("arst_held", held, 0);
    check("arst_btn", bus.evt_btn, 0);
    btn = 8'hFF;
    @(negedge CLK);
    reset_n = 1'b1;
    bus.evt_ready = 1'b1;
    nseen = 0;
    for (int c = 0; c < 40; c++) begin
      cyc(1);
      if (bus.evt_valid) nseen++;
    end
    check("arst_no_events", nseen, 0);

    // randomized traffic against the reference model
    model_reset();
    base = 8'hFF;
    seg = 30;
    glen = 0;
    gmask = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      check("rnd_held", held, mheld);
      check("rnd_overflow", overflow, 0);
      bus.evt_ready = ($urandom_range(3) != 0);
      if (bus.evt_valid && bus.evt_ready) pop_check();
      if (seg == 0) begin
        base ^= 8'($urandom_range(255));
        seg = $urandom_range(60, 20);
        if ($urandom_range(2) == 0) begin
          gmask = 8'($urandom_range(255));
          glen = $urandom_range(DEB - 4, 1);
        end
      end else begin
        seg--;
      end
      if (glen > 0 && seg < 10) begin
        b = base ^ gmask;
        glen--;
      end else begin
        b = base;
      end
      btn = b;
      model_step(b);
      @(negedge CLK);
    end
    btn = 8'hFF;
    for (int c = 0; c < 200; c++) begin
      check("rnd_drain_held", held, mheld);
      bus.evt_ready = 1'b1;
      if (bus.evt_valid) pop_check();
      model_step(8'hFF);
      @(negedge CLK);
    end
    check("rnd_left_expected", expq.size(), 0);
    check("rnd_final_valid", bus.evt_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/nes_button_events.md
# nes_button_events

Converts the eight raw button levels from the NES controller driver into a queued stream of debounced press/release events. Sits directly downstream of the controller read-out stage, in the system clock domain, and feeds game or menu logic through a valid/ready handshake. Replaces level polling by consumers and guarantees that no edge is silently lost.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before a level change is accepted (≥2).
- `FIFO_DEPTH`, 4: event queue depth (power of two, ≥2).
- `BTN_ACTIVE_LOW`, 1: 1 → `btn[i]`=0 means pressed (NES wire convention).
- `REPEAT_MASK`, 8'hF0: buttons eligible for auto-repeat (Up/Down/Left/Right).
- `REPEAT_DELAY`, 1000: held cycles before the first repeat event.
- `REPEAT_PERIOD`, 250: cycles between subsequent repeat events.

Ports:
- `CLK`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  when low, sync/debounce/repeat state holds and no new events are generated; the queue still drains.
- `btn`  in  8  raw levels, bit order A,B,Select,Start,Up,Down,Left,Right (bit 0..7); asynchronous to `CLK`.
- `evt_valid`  out  1  head of queue holds an event.
- `evt_ready`  in  1  consumer accepts head when `evt_valid & evt_ready`.
- `evt_btn`  out  3  button index of head event.
- `evt_press`  out  1  1 = press, 0 = release.
- `evt_repeat`  out  1  1 = auto-repeat press.
- `held`  out  8  debounced state, 1 = pressed.
- `overflow`  out  1  sticky: an event was lost.
- `clr_overflow`  in  1  synchronous clear of `overflow`.

## Operation
- Two-flop synchronizer per bit, then polarity normalization (pressed = 1).
- Debounce per bit: counter resets whenever synchronized level equals `held[i]`; otherwise increments; when it reaches `DEBOUNCE_CYCLES`, `held[i]` toggles and counter clears. A glitch shorter than `DEBOUNCE_CYCLES` never changes `held`.
- Each `held` toggle produces an edge: press on 0→1, release on 1→0.
- Per-button pending slot (occupied bit + direction + repeat bit). Edge into empty slot → slot filled. Opposite-direction edge into occupied slot → slot cleared (net zero) and `overflow` set. Repeat into occupied slot → dropped, no overflow.
- Enqueue: at most one event per cycle, lowest occupied index first, only when FIFO not full; slot clears on the cycle it enqueues.
- FIFO: simultaneous push and pop allowed when full (pop frees the entry). Head fields stable while `evt_valid & ~evt_ready`.
- `overflow` set has priority over `clr_overflow` in the same cycle.
- Reset: `held`=0, all slots empty, FIFO empty, `evt_valid`=0, `evt_btn`=0, `evt_press`=0, `evt_repeat`=0, `overflow`=0, all counters 0.

## Timing
- `btn` change (held steady) to `evt_valid` high, idle system with empty FIFO: `DEBOUNCE_CYCLES` + 4 cycles (2 sync, debounce, slot, FIFO).
- `held` updates one cycle before the event is written to its slot.
- Burst of N simultaneous edges: drains into FIFO at one per cycle, lowest index first.
- Repeat: first repeat press `REPEAT_DELAY` cycles after `held[i]` rises; then every `REPEAT_PERIOD` cycles while held; release resets the repeat counter.
- `en` low freezes all counters mid-count; resuming continues from the frozen value.
- `reset_n` assertion mid-operation clears everything immediately; queued events are discarded.

## Configuration
- `NES_AUTOREPEAT_EN` defined: per-button repeat counters for bits in `REPEAT_MASK`, repeat events as described, `evt_repeat` driven.
- Not defined: no repeat counters synthesized, `REPEAT_*` parameters ignored, `evt_repeat` tied 0, only real edges produce events.

## Test plan
- Reset, then `btn`=8'hFE steady (A pressed, active-low), `evt_ready`=1 → after 20 cycles one event `evt_btn`=0, `evt_press`=1; `held`=8'h01.
- Pulse `btn[3]` low for 10 cycles (< 16) → no event, `held` stays 0.
- Press A, Start and Right in the same cycle with `evt_ready`=0 → three queued events in order index 0, 3, 7; raise `evt_ready` → popped in that order, one per cycle.
- `evt_ready`=0, generate 6 press edges then release one still-pending button → FIFO holds 4, cancelled slot leaves no event, `overflow`=1; `clr_overflow` pulse → 0.
- With `NES_AUTOREPEAT_EN`, hold Up 1600 cycles → press at ~20, repeats (`evt_repeat`=1) at +1000, +1250, +1500; hold A → no repeats.
- Assert `reset_n` low with 3 events queued → `evt_valid`=0 and `held`=0 immediately, no events after release while `btn`=8'hFF.
